// File: rtl/cei_mochila_pkg.sv
// Cluster-level address map of the peripheral subsystem: port indices and
// start/end address rules used by reg_demux to select a peripheral port.
package cei_mochila_pkg;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_rule_t;

  localparam int unsigned NUM_PERIPHERALS = 2;

  localparam int unsigned BOOTROM_IDX = 0;
  localparam int unsigned MTIMER_IDX  = 1;

  localparam logic [31:0] BOOTROM_START_ADDR = 32'h0001_0000;
  localparam logic [31:0] BOOTROM_END_ADDR   = 32'h0001_1000;
  localparam logic [31:0] MTIMER_START_ADDR  = 32'h0002_0000;
  localparam logic [31:0] MTIMER_END_ADDR    = 32'h0002_0100;

  localparam addr_rule_t [NUM_PERIPHERALS-1:0] PERIPHERALS_ADDR_RULES = '{
    '{idx: 32'(MTIMER_IDX),  start_addr: MTIMER_START_ADDR,  end_addr: MTIMER_END_ADDR},
    '{idx: 32'(BOOTROM_IDX), start_addr: BOOTROM_START_ADDR, end_addr: BOOTROM_END_ADDR}
  };

endpackage

// File: rtl/cei_mtimer_pkg.sv
// Register map, widths and reset constants of the machine timer.
package cei_mtimer_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam int unsigned OFF_W      = 8;
  localparam int unsigned PRESCALE_W = 16;
  localparam int unsigned MTIME_W    = 64;
  localparam int unsigned MAX_HARTS  = 16;
  localparam int unsigned HART_IDX_W = 4;

  localparam logic [OFF_W-1:0] OFF_CTRL     = 8'h00;
  localparam logic [OFF_W-1:0] OFF_PRESCALE = 8'h04;
  localparam logic [OFF_W-1:0] OFF_MTIME_LO = 8'h08;
  localparam logic [OFF_W-1:0] OFF_MTIME_HI = 8'h0C;
  localparam logic [OFF_W-1:0] OFF_IRQ_EN   = 8'h10;
  localparam logic [OFF_W-1:0] OFF_IRQ_PEND = 8'h14;
  localparam logic [OFF_W-1:0] OFF_CMP_BASE = 8'h20;

  localparam logic [MTIME_W-1:0] CMP_RESET = '1;

  // Expand per-byte write strobes into a per-bit write mask.
  function automatic logic [DATA_W-1:0] strb_mask(input logic [STRB_W-1:0] wstrb);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < STRB_W; b++) begin
      m[8*b +: 8] = {8{wstrb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/reg_pkg.sv
// Register bus payloads shared by every reg_demux target in the peripheral subsystem.
//   reg_req_t : valid, write, addr, wdata, wstrb (request from reg_demux)
//   reg_rsp_t : ready, rdata, error (response to reg_demux)
package reg_pkg;

  localparam int unsigned REG_ADDR_W = 32;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_STRB_W = REG_DATA_W / 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic                  write;
    logic [REG_DATA_W-1:0] wdata;
    logic [REG_STRB_W-1:0] wstrb;
    logic                  valid;
  } reg_req_t;

  typedef struct packed {
    logic [REG_DATA_W-1:0] rdata;
    logic                  error;
    logic                  ready;
  } reg_rsp_t;

endpackage

// File: rtl/cei_mtimer_prescaler.sv
// Programmable tick divider for mtime.
//   clk_i, rst_i : clock, synchronous active-high reset
//   en           : counter runs only while set
//   prescale     : tick every prescale+1 enabled cycles
//   clear        : restart the count (software wrote PRESCALE)
//   tick         : combinational, high in the cycle mtime must advance
module cei_mtimer_prescaler
  import cei_mtimer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clear,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q;

  assign tick = en & (cnt_q == prescale);

  // Counter: wraps to zero on each tick, frozen while disabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/cei_mtimer.sv
// Machine timer: free-running 64-bit mtime with prescaler, one 64-bit compare
// register and one registered level interrupt per hart.
//   clk_i, rst_i : clock, synchronous active-high reset
//   reg_req_i    : register bus request (addr[7:0] decoded)
//   reg_rsp_o    : combinational single-cycle response
//   irq_o        : per-hart timer interrupt, irq_en & (mtime >= cmp)
module cei_mtimer
  import cei_mtimer_pkg::*;
#(
  parameter int unsigned NHARTS = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  reg_pkg::reg_req_t reg_req_i,
  output reg_pkg::reg_rsp_t reg_rsp_o,
  output logic [NHARTS-1:0] irq_o
);

  logic [OFF_W-1:0]      off;
  logic [OFF_W-1:0]      cmp_off;
  logic [HART_IDX_W-1:0] cmp_idx;
  logic                  cmp_half_hi;
  logic sel_ctrl, sel_presc, sel_lo, sel_hi, sel_ien, sel_pend, sel_cmp;
  logic decode_err;
  logic acc, wr_ok, rd_lo;
  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata_c;

  logic                  en_q;
  logic [PRESCALE_W-1:0] presc_q;
  logic [MTIME_W-1:0]    mtime_q, mtime_d;
  logic [DATA_W-1:0]     shadow_q;
  logic [NHARTS-1:0]     ien_q;
  logic [NHARTS-1:0]     pend;
  logic [NHARTS-1:0][MTIME_W-1:0] cmp_all;
  logic tick, presc_clr;

  logic unused_addr_bits;
  assign unused_addr_bits = ^reg_req_i.addr[reg_pkg::REG_ADDR_W-1:OFF_W];

  // Address decode on the low offset byte.
  always_comb begin
    off         = reg_req_i.addr[OFF_W-1:0];
    cmp_off     = off - OFF_CMP_BASE;
    cmp_idx     = cmp_off[6:3];
    cmp_half_hi = cmp_off[2];
    sel_ctrl    = 1'b0;
    sel_presc   = 1'b0;
    sel_lo      = 1'b0;
    sel_hi      = 1'b0;
    sel_ien     = 1'b0;
    sel_pend    = 1'b0;
    case (off)
      OFF_CTRL:     sel_ctrl  = 1'b1;
      OFF_PRESCALE: sel_presc = 1'b1;
      OFF_MTIME_LO: sel_lo    = 1'b1;
      OFF_MTIME_HI: sel_hi    = 1'b1;
      OFF_IRQ_EN:   sel_ien   = 1'b1;
      OFF_IRQ_PEND: sel_pend  = 1'b1;
      default: ;
    endcase
    // CMP window is 0x20..0x9F, word aligned, limited to implemented harts.
    sel_cmp = (off >= OFF_CMP_BASE) && !cmp_off[7] && (cmp_off[1:0] == 2'b00)
              && (32'(cmp_idx) < NHARTS);
    decode_err = ~(sel_ctrl | sel_presc | sel_lo | sel_hi | sel_ien | sel_pend | sel_cmp);
  end

  // Accesses during reset are discarded.
  assign acc       = reg_req_i.valid & ~rst_i;
  assign wr_ok     = acc & reg_req_i.write & ~decode_err;
  assign rd_lo     = acc & ~reg_req_i.write & sel_lo;
  assign wmask     = strb_mask(reg_req_i.wstrb);
  assign wdata     = reg_req_i.wdata;
  assign presc_clr = wr_ok & sel_presc;

  cei_mtimer_prescaler u_prescaler (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en       (en_q),
    .prescale (presc_q),
    .clear    (presc_clr),
    .tick     (tick)
  );

  // mtime next value: a software write to either half suppresses the tick.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_ok && sel_lo) begin
      mtime_d[31:0] = (mtime_q[31:0] & ~wmask) | (wdata & wmask);
    end else if (wr_ok && sel_hi) begin
      mtime_d[63:32] = (mtime_q[63:32] & ~wmask) | (wdata & wmask);
    end else if (tick) begin
      mtime_d = mtime_q + MTIME_W'(1);
    end
  end

  // Control, prescale, mtime, irq enable and the hi shadow for atomic reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q     <= 1'b0;
      presc_q  <= '0;
      mtime_q  <= '0;
      ien_q    <= '0;
      shadow_q <= '0;
    end else begin
      mtime_q <= mtime_d;
      if (wr_ok && sel_ctrl && wmask[0]) begin
        en_q <= wdata[0];
      end
      if (presc_clr) begin
        presc_q <= (presc_q & ~wmask[PRESCALE_W-1:0]) | (wdata[PRESCALE_W-1:0] & wmask[PRESCALE_W-1:0]);
      end
      if (wr_ok && sel_ien) begin
        ien_q <= (ien_q & ~wmask[NHARTS-1:0]) | (wdata[NHARTS-1:0] & wmask[NHARTS-1:0]);
      end
      if (rd_lo) begin
        shadow_q <= mtime_q[63:32];
      end
    end
  end

  // Per-hart compare register and registered interrupt.
  for (genvar h = 0; h < NHARTS; h++) begin : g_hart
    logic [MTIME_W-1:0] cmp_q;
    logic               irq_q;
    logic               wr_this;

    assign wr_this    = wr_ok & sel_cmp & (cmp_idx == HART_IDX_W'(h));
    assign pend[h]    = (mtime_q >= cmp_q);
    assign cmp_all[h] = cmp_q;
    assign irq_o[h]   = irq_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cmp_q <= CMP_RESET;
        irq_q <= 1'b0;
      end else begin
        if (wr_this && !cmp_half_hi) begin
          cmp_q[31:0] <= (cmp_q[31:0] & ~wmask) | (wdata & wmask);
        end
        if (wr_this && cmp_half_hi) begin
          cmp_q[63:32] <= (cmp_q[63:32] & ~wmask) | (wdata & wmask);
        end
        irq_q <= ien_q[h] & pend[h];
      end
    end
  end

  // Read data mux; unmapped offsets read as zero.
  always_comb begin
    rdata_c = '0;
    if (sel_ctrl)  rdata_c = DATA_W'(en_q);
    if (sel_presc) rdata_c = DATA_W'(presc_q);
    if (sel_lo)    rdata_c = mtime_q[31:0];
    if (sel_hi)    rdata_c = shadow_q;
    if (sel_ien)   rdata_c = DATA_W'(ien_q);
    if (sel_pend)  rdata_c = DATA_W'(pend);
    if (sel_cmp) begin
      for (int h = 0; h < NHARTS; h++) begin
        if (cmp_idx == HART_IDX_W'(h)) begin
          rdata_c = cmp_half_hi ? cmp_all[h][63:32] : cmp_all[h][31:0];
        end
      end
    end
  end

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = reg_req_i.valid;
    reg_rsp_o.rdata = acc ? rdata_c : '0;
    reg_rsp_o.error = acc & decode_err;
  end

endmodule

// File: tb/tb_cei_mtimer.sv
// Randomised scoreboard bench for cei_mtimer against a transaction-level model.
module tb_cei_mtimer;
  import reg_pkg::*;
  import cei_mochila_pkg::*;

  localparam int unsigned NH = 3;

  logic          clk = 1'b0;
  logic          rst;
  reg_req_t      req;
  reg_rsp_t      rsp;
  logic [NH-1:0] irq;

  cei_mtimer #(.NHARTS(NH)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .reg_req_i (req),
    .reg_rsp_o (rsp),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];
  string       name_q[$];
  bit          mon_on = 1'b0;
  logic [32:0] mon_e;
  string       mon_nm;

  // Reference model state
  bit            m_en;
  bit [15:0]     m_presc, m_cnt;
  bit [63:0]     m_mtime;
  bit [31:0]     m_shadow;
  bit [NH-1:0]   m_ien, m_irq;
  bit [63:0]     m_cmp [NH];

  function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] mask;
    mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
    return (old & ~mask) | (wd & mask);
  endfunction

  task automatic model_reset();
    m_en = 0; m_presc = 0; m_cnt = 0; m_mtime = 0; m_shadow = 0; m_ien = 0; m_irq = 0;
    for (int h = 0; h < int'(NH); h++) m_cmp[h] = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  task automatic exp_rsp(input logic [7:0] off, input bit r, output logic [31:0] d, output bit e);
    int h;
    d = 0; e = 0;
    if (!r) begin
      case (off)
        8'h00: d = {31'b0, m_en};
        8'h04: d = {16'b0, m_presc};
        8'h08: d = m_mtime[31:0];
        8'h0C: d = m_shadow;
        8'h10: d = 32'(m_ien);
        8'h14: for (int k = 0; k < int'(NH); k++) d[k] = (m_mtime >= m_cmp[k]);
        default: begin
          h = (int'(off) - 32) / 8;
          if (off >= 8'h20 && off[1:0] == 2'b00 && h < int'(NH))
            d = off[2] ? m_cmp[h][63:32] : m_cmp[h][31:0];
          else
            e = 1;
        end
      endcase
    end
  endtask

  // Advance the model by one clock edge given the access presented in that cycle.
  task automatic model_step(input bit v, input bit w, input logic [7:0] off,
                            input logic [31:0] wd, input logic [3:0] ws, input bit r);
    logic [31:0] d; bit err, wr, rd, tick; bit [NH-1:0] nirq; int h;
    if (r) begin
      model_reset();
    end else begin
      exp_rsp(off, 1'b0, d, err);
      wr   = v && w && !err;
      rd   = v && !w;
      tick = m_en && (m_cnt == m_presc);
      for (int k = 0; k < int'(NH); k++) nirq[k] = m_ien[k] && (m_mtime >= m_cmp[k]);
      if (rd && off == 8'h08) m_shadow = m_mtime[63:32];
      if (wr && off == 8'h04) m_cnt = 0;
      else if (m_en) m_cnt = tick ? 16'd0 : m_cnt + 16'd1;
      if (wr && off == 8'h08)      m_mtime[31:0]  = mrg(m_mtime[31:0], wd, ws);
      else if (wr && off == 8'h0C) m_mtime[63:32] = mrg(m_mtime[63:32], wd, ws);
      else if (tick)               m_mtime = m_mtime + 64'd1;
      if (wr && off == 8'h00 && ws[0]) m_en = wd[0];
      if (wr && off == 8'h04) m_presc = 16'(mrg(32'(m_presc), wd, ws));
      if (wr && off == 8'h10) m_ien = NH'(mrg(32'(m_ien), wd, ws));
      if (wr && off >= 8'h20) begin
        h = (int'(off) - 32) / 8;
        if (off[2]) m_cmp[h][63:32] = mrg(m_cmp[h][63:32], wd, ws);
        else        m_cmp[h][31:0]  = mrg(m_cmp[h][31:0], wd, ws);
      end
      m_irq = nirq;
    end
  endtask

  // One bus cycle: drive, push expectation, step the model at the edge.
  task automatic cyc(input bit v, input bit w, input logic [7:0] off, input logic [31:0] wd,
                     input logic [3:0] ws, input bit r, input string nm);
    logic [31:0] d; bit e;
    req.valid = v; req.write = w; req.addr = MTIMER_START_ADDR | 32'(off);
    req.wdata = wd; req.wstrb = ws; rst = r;
    if (v) begin
      exp_rsp(off, r, d, e);
      exp_q.push_back({e, d});
      name_q.push_back(nm);
    end
    @(posedge clk);
    model_step(v, w, off, wd, ws, r);
    #1;
    req.valid = 1'b0; rst = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] ws = 4'hF);
    cyc(1'b1, 1'b1, off, wd, ws, 1'b0, "write");
  endtask

  task automatic rd(input logic [7:0] off, input string nm);
    cyc(1'b1, 1'b0, off, 32'h0, 4'h0, 1'b0, nm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, "idle");
  endtask

  // Monitor: irq_o every cycle, bus response whenever a request is presented.
  always @(negedge clk) begin
    if (mon_on) begin
      n_checks++;
      if (irq !== m_irq) begin
        n_errors++;
        $display("FAIL irq_o at %0t: got %b expected %b", $time, irq, m_irq);
      end
    end
    if (req.valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_rsp at %0t: response with no expectation queued", $time);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        if (rsp.ready !== 1'b1 || rsp.error !== mon_e[32] || rsp.rdata !== mon_e[31:0]) begin
          n_errors++;
          $display("FAIL %s at %0t: got ready=%b error=%b rdata=%h, expected ready=1 error=%b rdata=%h",
                   mon_nm, $time, rsp.ready, rsp.error, rsp.rdata, mon_e[32], mon_e[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog at %0t: got no finish, expected finish before timeout", $time);
    $fatal(1, "timeout");
  end

  logic [7:0]  offs [17] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h24,
                             8'h28, 8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C, 8'h18, 8'hFC, 8'h01};
  int          k;
  logic [7:0]  roff;
  logic [31:0] rwd;
  logic [3:0]  rws;

  initial begin
    model_reset();
    req = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 8'h08, 32'h0, 4'h0, 1'b1, "read_during_reset");
    mon_on = 1'b1;

    // Reset state and decode errors
    rd(8'h08, "rst_mtime_lo");
    rd(8'h0C, "rst_mtime_hi");
    rd(8'h20, "rst_cmp0_lo");
    rd(8'h24, "rst_cmp0_hi");
    rd(8'hFC, "unmapped_fc");
    rd(8'h38, "cmp_hart3_err");
    wr(8'hFC, 32'hFFFF_FFFF);
    wr(8'h14, 32'hFFFF_FFFF);
    rd(8'h14, "irq_pend_ro");

    // Prescaler = 3
    wr(8'h04, 32'd3);
    wr(8'h00, 32'd1);
    idle(40);
    rd(8'h08, "presc3_mtime_lo");

    // Prescaler = 0
    wr(8'h00, 32'd0);
    wr(8'h04, 32'd0);
    wr(8'h00, 32'd1);
    idle(5);
    rd(8'h08, "presc0_lo_a");
    rd(8'h08, "presc0_lo_b");
    rd(8'h08, "presc0_lo_c");

    // IRQ on hart 1
    wr(8'h00, 32'd0);
    wr(8'h08, 32'd90);
    wr(8'h0C, 32'd0);
    wr(8'h28, 32'd100);
    wr(8'h2C, 32'd0);
    wr(8'h10, 32'b010);
    wr(8'h00, 32'd1);
    idle(20);
    rd(8'h14, "irq_pend_after");
    wr(8'h2C, 32'd1);
    idle(3);
    rd(8'h2C, "cmp1_hi");

    // Atomic read across a carry into the high half
    wr(8'h00, 32'd0);
    wr(8'h08, 32'hFFFF_FFF0);
    wr(8'h0C, 32'd0);
    wr(8'h00, 32'd1);
    rd(8'h08, "atomic_lo");
    idle(30);
    rd(8'h0C, "atomic_hi_shadow");
    rd(8'h08, "atomic_lo_again");
    rd(8'h0C, "atomic_hi_new");

    // Byte write colliding with a tick
    wr(8'h08, 32'h0000_0055, 4'b0001);
    rd(8'h08, "collision_lo");

    // Wrap drops irq 0
    wr(8'h00, 32'd0);
    wr(8'h08, 32'hFFFF_FFFF);
    wr(8'h0C, 32'hFFFF_FFFF);
    wr(8'h20, 32'd5);
    wr(8'h24, 32'd0);
    wr(8'h10, 32'b001);
    idle(2);
    wr(8'h00, 32'd1);
    idle(5);
    rd(8'h08, "wrap_lo");
    rd(8'h14, "wrap_pend");

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      k    = int'($urandom_range(0, 9));
      roff = offs[$urandom_range(0, 16)];
      rws  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case (roff)
        8'h00, 8'h04:              rwd = 32'($urandom_range(0, 3));
        8'h0C, 8'h24, 8'h2C, 8'h34: rwd = m_mtime[63:32];
        8'h20, 8'h28, 8'h30:        rwd = m_mtime[31:0] + 32'($urandom_range(0, 40));
        default:                   rwd = $urandom;
      endcase
      if (k < 4)      idle(1);
      else if (k < 7) cyc(1'b1, 1'b1, roff, rwd, rws, 1'b0, "rand_wr");
      else            cyc(1'b1, 1'b0, roff, 32'h0, 4'h0, 1'b0, "rand_rd");
    end

    // Reset mid-count
    wr(8'h04, 32'd0);
    wr(8'h00, 32'd1);
    wr(8'h10, 32'b111);
    wr(8'h20, 32'd0);
    wr(8'h24, 32'd0);
    idle(3);
    cyc(1'b1, 1'b1, 8'h08, 32'h1234, 4'hF, 1'b1, "write_during_reset");
    rd(8'h08, "midrst_lo");
    rd(8'h0C, "midrst_hi");
    rd(8'h00, "midrst_ctrl");
    rd(8'h04, "midrst_prescale");
    rd(8'h10, "midrst_irq_en");
    rd(8'h20, "midrst_cmp0_lo");
    rd(8'h2C, "midrst_cmp1_hi");
    idle(2);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cei_mtimer.md
# cei_mtimer

Machine-timer peripheral on one `reg_demux` output port of the peripheral subsystem; consumes `reg_req_t` and produces `reg_rsp_t` like the boot ROM beside it. It holds a free-running 64-bit `mtime` with programmable prescaler, one 64-bit compare register per hart, and a registered per-hart timer interrupt. It provides the timer interrupts for the `NHARTS` cores of the CEI mochila cluster.

## Interface
- `NHARTS`, default 3: number of harts, one compare register and one irq line each. Legal range 1..16.
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: synchronous reset, active-high.
- `reg_req_i`, input, `reg_pkg::reg_req_t`: register bus request (`valid`, `write`, `addr`, `wdata`, `wstrb`).
- `reg_rsp_o`, output, `reg_pkg::reg_rsp_t`: register bus response (`ready`, `rdata`, `error`).
- `irq_o`, output, `NHARTS`: per-hart timer interrupt, level, registered.

## Operation
- Decode uses `addr[7:0]`; upper bits are ignored because upstream decode has already selected the port.
- Register map, all 32-bit:
  - 0x00 CTRL: bit0 EN.
  - 0x04 PRESCALE: bits [15:0].
  - 0x08 MTIME_LO.
  - 0x0C MTIME_HI.
  - 0x10 IRQ_EN: bits [NHARTS-1:0].
  - 0x14 IRQ_PEND: read-only; bit h = (mtime >= cmp[h]).
  - 0x20+8h CMP_LO[h].
  - 0x24+8h CMP_HI[h].
- Reset values:
  - ctrl, prescale, mtime, irq_en, prescale counter, hi shadow, `irq_o` = 0.
  - cmp[h] = 64'hFFFF_FFFF_FFFF_FFFF.
- Prescaler:
  - 16-bit counter runs only while EN=1.
  - When counter == PRESCALE, a tick is produced and the counter clears; otherwise the counter increments.
  - PRESCALE=0 gives one tick per cycle.
  - Any write to PRESCALE clears the counter.
  - EN=0 freezes both the counter and mtime.
- mtime: +1 per tick, unsigned 64-bit, wraps from 2^64-1 to 0.
- Writes:
  - Honour `wstrb` per byte.
  - Unwritten bits of read-only or narrower fields are ignored.
  - A write to MTIME_LO/HI in the same cycle as a tick: the written bytes take the written value, and the unwritten half keeps its old value with no increment. Software writes always win.
  - No carry propagates from a tick into a half being written.
- Atomic 64-bit read:
  - Reading MTIME_LO captures mtime[63:32] into a hi shadow.
  - Reading MTIME_HI returns the shadow, not live mtime.
  - The shadow is not updated by any other access.
- IRQ: `irq_o[h]` <= `irq_en[h]` & (mtime >= cmp[h]), computed from register values at each edge.
- Errors:
  - Accesses to an unmapped offset, or to CMP of hart >= NHARTS, return `error`=1 and `rdata`=0.
  - Writes that return an error have no effect.
  - Writes to IRQ_PEND are silently ignored with `error`=0.

## Timing
- Bus response is combinational, single cycle: `ready` = 1 whenever `valid`; `rdata` and `error` are valid in the same cycle.
- Register writes take effect at the clock edge ending the access cycle. A read in the next cycle returns the new value.
- The hi shadow is captured at the edge ending the MTIME_LO read cycle.
- IRQ latency:
  - `irq_o[h]` rises one cycle after the cycle in which mtime first equals cmp[h].
  - It falls one cycle after a cmp/irq_en/mtime write makes the condition false, or after mtime wraps.
- Reset mid-operation: at the first edge with `rst_i`=1, all state returns to reset values. `irq_o` is 0 in the following cycle. A bus access in the reset cycle is discarded; it still returns `ready`=1 with `rdata`=0.

## Structure
- In `cei_mochila_pkg`: `MTIMER_IDX`, the MTIMER start/end address constants, and the rule entry in `PERIPHERALS_ADDR_RULES`.
- Register offset localparams go in a new `cei_mtimer_pkg`.
- One sub-module, `cei_mtimer_prescaler`:
  - Inputs: `clk_i`, `rst_i`, en, prescale, clear.
  - Output: tick.
- Compare and irq logic use a generate loop over `NHARTS`.

## Test plan
- Reset state:
  - Reset, then read 0x08, 0x0C, 0x20, 0x24 -> 0, 0, 0xFFFFFFFF, 0xFFFFFFFF.
  - `irq_o`=0.
  - Read 0xFC -> `error`=1.
- Prescaler:
  - PRESCALE=3, CTRL=1, run 40 cycles, read MTIME_LO -> 10 (±1 for write alignment; check the exact value against the model).
  - PRESCALE=0 -> +1 every cycle.
- IRQ:
  - Set CMP[1]=100, IRQ_EN=0b010, CTRL=1 with PRESCALE=0.
  - `irq_o[1]` rises exactly 1 cycle after mtime==100; `irq_o[0]`/`irq_o[2]` stay 0.
  - Writing CMP_HI[1]=1 drops it 1 cycle later.
- Atomic read:
  - MTIME=0x0000_0000_FFFF_FFF0, PRESCALE=0.
  - Read LO, wait 30 cycles, read HI -> HI=0 (the shadow), although live HI=1.
- Write/tick collision: write MTIME_LO=0x55 with `wstrb`=0001 in a tick cycle -> LO becomes (old & 0xFFFFFF00)|0x55, not incremented.
- Wrap and reset:
  - MTIME=2^64-1 with CMP[0]=5 and IRQ active -> mtime=0 next tick, `irq_o[0]` falls.
  - Assert `rst_i` mid-count -> all registers return to reset values next cycle.
